// File: rtl/ls_array_sequencer_pkg.sv
// Shared types and precision constants for the load/store-array sequencer.
// Lane counts describe how many operands fit in one 64-bit FIFO word.
package ls_array_sequencer_pkg;

  typedef enum logic [1:0] {
    CNT_UP_WRAP   = 2'd0,
    CNT_DN_RELOAD = 2'd1,
    CNT_UP_SAT    = 2'd2
  } cnt_mode_e;

  typedef enum logic [1:0] {
    PREC_INT8  = 2'd0,
    PREC_INT16 = 2'd1,
    PREC_INT32 = 2'd2,
    PREC_INT64 = 2'd3
  } prec_e;

  localparam int LANES_INT8  = 8;
  localparam int LANES_INT16 = 4;
  localparam int LANES_INT32 = 2;
  localparam int LANES_INT64 = 1;

  function automatic int lanes_for_prec(prec_e p);
    unique case (p)
      PREC_INT8:  return LANES_INT8;
      PREC_INT16: return LANES_INT16;
      PREC_INT32: return LANES_INT32;
      default:    return LANES_INT64;
    endcase
  endfunction

endpackage

// File: rtl/ls_mod_counter.sv
// Loadable counter with wrap, down-reload or saturate behaviour.
// o_flag is a wrap/reload pulse, or a done level in saturate mode.
module ls_mod_counter
  import ls_array_sequencer_pkg::*;
#(
  parameter int        W    = 3,
  parameter cnt_mode_e MODE = CNT_UP_WRAP
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_ld,
  input  logic         i_en,
  input  logic [W-1:0] i_max,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_cnt_nxt,
  output logic         o_flag
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_max;
  logic         r_flag;
  logic [W-1:0] w_cnt_nxt;
  logic [W-1:0] w_max_nxt;
  logic         w_evt;
  logic         w_flag_nxt;

  // Next count, maximum and flag; load always beats enable.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_max_nxt = r_max;
    w_evt     = 1'b0;
    if (i_ld) begin
      w_max_nxt = i_max;
      w_cnt_nxt = (MODE == CNT_DN_RELOAD) ? i_max : '0;
    end else if (i_en) begin
      unique case (MODE)
        CNT_UP_WRAP: begin
          if (r_cnt == r_max) begin
            w_cnt_nxt = '0;
            w_evt     = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        CNT_DN_RELOAD: begin
          if (r_cnt == '0) begin
            w_cnt_nxt = r_max;
            w_evt     = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        default: begin
          if (r_cnt < r_max) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      endcase
    end
    if (MODE == CNT_UP_SAT) begin
      w_flag_nxt = (w_cnt_nxt == w_max_nxt);
    end else begin
      w_flag_nxt = w_evt;
    end
  end

  // State registers; a saturating counter with max 0 is already done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_max  <= '0;
      r_flag <= (MODE == CNT_UP_SAT);
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_max  <= w_max_nxt;
      r_flag <= w_flag_nxt;
    end
  end

  assign o_cnt     = r_cnt;
  assign o_cnt_nxt = w_cnt_nxt;
  assign o_flag    = r_flag;

endmodule

// File: rtl/ls_array_sequencer.sv
// Load/store-array sequencer: lane selects, weight row addresses,
// qualified FIFO strobes and sticky protocol error flags.
module ls_array_sequencer
  import ls_array_sequencer_pkg::*;
#(
  parameter int ROWS                 = 3,
  parameter int COLUMNS              = 3,
  parameter int DATA_WIDTH_FIFO_IN   = 64,
  parameter int ADDRESS_SIZE_WMEMORY = 32,
  parameter int CW                   = $clog2(COLUMNS) + 1,
  parameter int RW                   = $clog2(ROWS) + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDRESS_SIZE_WMEMORY-1:0] wm_base_addr,
  input  logic                            enable_cnt,
  input  logic                            ld_max_cnt,
  input  logic [CW-1:0]                   max_cnt_from_cu,
  input  logic                            enable_down_cnt,
  input  logic                            ld_max_down_cnt,
  input  logic [CW-1:0]                   max_down_cnt_from_cu,
  input  logic                            enable_cnt_weight,
  input  logic                            ld_max_cnt_weight,
  input  logic [RW-1:0]                   max_cnt_weight_from_cu,
  input  logic                            enable_load_activation_data,
  input  logic                            enable_store_activation_data,
  input  logic                            infifo_is_empty,
  input  logic                            outfifo_is_full,
  output logic [ADDRESS_SIZE_WMEMORY-1:0] wm_address,
  output logic [CW-1:0]                   act_lane_sel,
  output logic [CW-1:0]                   out_lane_sel,
  output logic                            act_load_strobe,
  output logic                            store_strobe,
  output logic                            cnt_wrap,
  output logic                            down_wrap,
  output logic                            weight_done,
  output logic                            underflow_err,
  output logic                            overflow_err
);

  localparam int AW = ADDRESS_SIZE_WMEMORY;

  logic [AW-1:0] r_wm_base;
  logic [AW-1:0] r_wm_addr;
  logic          r_ld_stb;
  logic          r_st_stb;
  logic          r_uf;
  logic          r_ov;
  logic [AW-1:0] w_base_nxt;
  logic [RW-1:0] w_wcnt;
  logic [RW-1:0] w_wcnt_nxt;
  logic [CW-1:0] w_ucnt_nxt;
  logic [CW-1:0] w_dcnt_nxt;
  logic          w_uf_set;
  logic          w_ov_set;
  logic          w_unused;

  ls_mod_counter #(
    .W    (CW),
    .MODE (CNT_UP_WRAP)
  ) u_up (
    .clk       (clk),
    .reset     (reset),
    .i_ld      (ld_max_cnt),
    .i_en      (enable_cnt),
    .i_max     (max_cnt_from_cu),
    .o_cnt     (act_lane_sel),
    .o_cnt_nxt (w_ucnt_nxt),
    .o_flag    (cnt_wrap)
  );

  ls_mod_counter #(
    .W    (CW),
    .MODE (CNT_DN_RELOAD)
  ) u_dn (
    .clk       (clk),
    .reset     (reset),
    .i_ld      (ld_max_down_cnt),
    .i_en      (enable_down_cnt),
    .i_max     (max_down_cnt_from_cu),
    .o_cnt     (out_lane_sel),
    .o_cnt_nxt (w_dcnt_nxt),
    .o_flag    (down_wrap)
  );

  ls_mod_counter #(
    .W    (RW),
    .MODE (CNT_UP_SAT)
  ) u_wt (
    .clk       (clk),
    .reset     (reset),
    .i_ld      (ld_max_cnt_weight),
    .i_en      (enable_cnt_weight),
    .i_max     (max_cnt_weight_from_cu),
    .o_cnt     (w_wcnt),
    .o_cnt_nxt (w_wcnt_nxt),
    .o_flag    (weight_done)
  );

  assign w_base_nxt = ld_max_cnt_weight ? wm_base_addr : r_wm_base;
  assign w_uf_set   = enable_load_activation_data & infifo_is_empty;
  assign w_ov_set   = enable_store_activation_data & outfifo_is_full;

  // Address, strobe and error registers; a new error beats the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wm_base <= '0;
      r_wm_addr <= '0;
      r_ld_stb  <= 1'b0;
      r_st_stb  <= 1'b0;
      r_uf      <= 1'b0;
      r_ov      <= 1'b0;
    end else begin
      r_wm_base <= w_base_nxt;
      r_wm_addr <= w_base_nxt + AW'(w_wcnt_nxt);
      r_ld_stb  <= enable_load_activation_data & ~infifo_is_empty;
      r_st_stb  <= enable_store_activation_data & ~outfifo_is_full;
      r_uf      <= w_uf_set | (r_uf & ~ld_max_cnt);
      r_ov      <= w_ov_set | (r_ov & ~ld_max_cnt);
    end
  end

  assign wm_address      = r_wm_addr;
  assign act_load_strobe = r_ld_stb;
  assign store_strobe    = r_st_stb;
  assign underflow_err   = r_uf;
  assign overflow_err    = r_ov;

  assign w_unused = ^{w_wcnt, w_ucnt_nxt, w_dcnt_nxt,
                      DATA_WIDTH_FIFO_IN[0]};

endmodule

// File: tb/tb_ls_array_sequencer.sv
// Scoreboard bench for ls_array_sequencer with directed vectors.
// Stimulus queues expectations; a monitor checks after each edge.
module tb_ls_array_sequencer;

  localparam int AW = 32;
  localparam int CW = 3;
  localparam int RW = 3;

  localparam int S_WM  = 0;
  localparam int S_ACT = 1;
  localparam int S_OUT = 2;
  localparam int S_AS  = 3;
  localparam int S_SS  = 4;
  localparam int S_CW  = 5;
  localparam int S_DW  = 6;
  localparam int S_WD  = 7;
  localparam int S_UF  = 8;
  localparam int S_OV  = 9;

  typedef struct {
    int          cyc;
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] wm_base_addr;
  logic          enable_cnt;
  logic          ld_max_cnt;
  logic [CW-1:0] max_cnt_from_cu;
  logic          enable_down_cnt;
  logic          ld_max_down_cnt;
  logic [CW-1:0] max_down_cnt_from_cu;
  logic          enable_cnt_weight;
  logic          ld_max_cnt_weight;
  logic [RW-1:0] max_cnt_weight_from_cu;
  logic          enable_load_activation_data;
  logic          enable_store_activation_data;
  logic          infifo_is_empty;
  logic          outfifo_is_full;
  logic [AW-1:0] wm_address;
  logic [CW-1:0] act_lane_sel;
  logic [CW-1:0] out_lane_sel;
  logic          act_load_strobe;
  logic          store_strobe;
  logic          cnt_wrap;
  logic          down_wrap;
  logic          weight_done;
  logic          underflow_err;
  logic          overflow_err;

  chk_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ls_array_sequencer dut (
    .clk                          (clk),
    .reset                        (reset),
    .wm_base_addr                 (wm_base_addr),
    .enable_cnt                   (enable_cnt),
    .ld_max_cnt                   (ld_max_cnt),
    .max_cnt_from_cu              (max_cnt_from_cu),
    .enable_down_cnt              (enable_down_cnt),
    .ld_max_down_cnt              (ld_max_down_cnt),
    .max_down_cnt_from_cu         (max_down_cnt_from_cu),
    .enable_cnt_weight            (enable_cnt_weight),
    .ld_max_cnt_weight            (ld_max_cnt_weight),
    .max_cnt_weight_from_cu       (max_cnt_weight_from_cu),
    .enable_load_activation_data  (enable_load_activation_data),
    .enable_store_activation_data (enable_store_activation_data),
    .infifo_is_empty              (infifo_is_empty),
    .outfifo_is_full              (outfifo_is_full),
    .wm_address                   (wm_address),
    .act_lane_sel                 (act_lane_sel),
    .out_lane_sel                 (out_lane_sel),
    .act_load_strobe              (act_load_strobe),
    .store_strobe                 (store_strobe),
    .cnt_wrap                     (cnt_wrap),
    .down_wrap                    (down_wrap),
    .weight_done                  (weight_done),
    .underflow_err                (underflow_err),
    .overflow_err                 (overflow_err)
  );

  function automatic logic [31:0] get(int s);
    case (s)
      S_WM:    return wm_address;
      S_ACT:   return 32'(act_lane_sel);
      S_OUT:   return 32'(out_lane_sel);
      S_AS:    return 32'(act_load_strobe);
      S_SS:    return 32'(store_strobe);
      S_CW:    return 32'(cnt_wrap);
      S_DW:    return 32'(down_wrap);
      S_WD:    return 32'(weight_done);
      S_UF:    return 32'(underflow_err);
      default: return 32'(overflow_err);
    endcase
  endfunction

  task automatic idle();
    reset                        = 1'b0;
    wm_base_addr                 = '0;
    enable_cnt                   = 1'b0;
    ld_max_cnt                   = 1'b0;
    max_cnt_from_cu              = '0;
    enable_down_cnt              = 1'b0;
    ld_max_down_cnt              = 1'b0;
    max_down_cnt_from_cu         = '0;
    enable_cnt_weight            = 1'b0;
    ld_max_cnt_weight            = 1'b0;
    max_cnt_weight_from_cu       = '0;
    enable_load_activation_data  = 1'b0;
    enable_store_activation_data = 1'b0;
    infifo_is_empty              = 1'b0;
    outfifo_is_full              = 1'b0;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  task automatic ex(string n, int s, logic [31:0] v);
    chk_t c;
    c.cyc  = cyc + 1;
    c.name = n;
    c.sel  = s;
    c.exp  = v;
    q.push_back(c);
  endtask

  task automatic ex_all_reset(string n);
    ex({n, " wm"}, S_WM, 0);
    ex({n, " act"}, S_ACT, 0);
    ex({n, " out"}, S_OUT, 0);
    ex({n, " as"}, S_AS, 0);
    ex({n, " ss"}, S_SS, 0);
    ex({n, " cw"}, S_CW, 0);
    ex({n, " dw"}, S_DW, 0);
    ex({n, " wd"}, S_WD, 1);
    ex({n, " uf"}, S_UF, 0);
    ex({n, " ov"}, S_OV, 0);
  endtask

  // Monitor: after each rising edge, retire the checks due this cycle.
  initial begin
    chk_t c;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        c = q.pop_front();
        total++;
        if (get(c.sel) !== c.exp) begin
          bad++;
          $display("FAIL %s got=%0h want=%0h cyc=%0d",
                   c.name, get(c.sel), c.exp, cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int du [5] = '{2, 1, 0, 3, 2};
    int dw [5] = '{0, 0, 0, 1, 0};
    idle();
    reset = 1'b1;

    nxt(); reset = 1'b1;
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b1;
    ex_all_reset("rst");
    nxt();
    ex_all_reset("rel");

    nxt(); ld_max_cnt_weight = 1; max_cnt_weight_from_cu = 3;
    ex("ldw wd", S_WD, 0);
    ex("ldw wm", S_WM, 0);

    nxt(); ld_max_cnt = 1; max_cnt_from_cu = 2;
    ex("ldu act", S_ACT, 0);
    ex("ldu cw", S_CW, 0);
    for (int k = 1; k <= 7; k++) begin
      nxt(); enable_cnt = 1;
      ex($sformatf("up%0d act", k), S_ACT, 32'(k % 3));
      ex($sformatf("up%0d cw", k), S_CW, 32'(k % 3 == 0));
    end
    nxt(); ld_max_cnt = 1; max_cnt_from_cu = 0; enable_cnt = 1;
    ex("ldu+en act", S_ACT, 0);
    ex("ldu+en cw", S_CW, 0);
    nxt(); enable_cnt = 1;
    ex("max0 act", S_ACT, 0);
    ex("max0 cw", S_CW, 1);
    nxt(); enable_cnt = 1;
    ex("max0 cw2", S_CW, 1);
    nxt();
    ex("idle cw", S_CW, 0);

    nxt(); ld_max_down_cnt = 1; max_down_cnt_from_cu = 3;
    ex("ldd out", S_OUT, 3);
    ex("ldd dw", S_DW, 0);
    for (int k = 0; k < 5; k++) begin
      nxt(); enable_down_cnt = 1;
      ex($sformatf("dn%0d out", k), S_OUT, 32'(du[k]));
      ex($sformatf("dn%0d dw", k), S_DW, 32'(dw[k]));
    end
    nxt(); ld_max_down_cnt = 1; max_down_cnt_from_cu = 3;
    enable_down_cnt = 1;
    ex("ldd+en out", S_OUT, 3);
    ex("ldd+en dw", S_DW, 0);

    nxt(); ld_max_cnt_weight = 1; max_cnt_weight_from_cu = 3;
    wm_base_addr = 32'h100;
    ex("wt0 wm", S_WM, 32'h100);
    ex("wt0 wd", S_WD, 0);
    for (int k = 1; k <= 5; k++) begin
      nxt(); enable_cnt_weight = 1;
      ex($sformatf("wt%0d wm", k), S_WM,
         32'h100 + 32'((k > 3) ? 3 : k));
      ex($sformatf("wt%0d wd", k), S_WD, 32'(k >= 3));
    end
    nxt(); ld_max_cnt_weight = 1; max_cnt_weight_from_cu = 2;
    wm_base_addr = 32'hFFFF_FFFF;
    ex("wrapw wm", S_WM, 32'hFFFF_FFFF);
    nxt(); enable_cnt_weight = 1;
    ex("wrapw wm+1", S_WM, 32'h0);
    ex("wrapw wd", S_WD, 0);
    nxt(); ld_max_cnt_weight = 1; max_cnt_weight_from_cu = 0;
    wm_base_addr = 32'h40;
    ex("w0 wd", S_WD, 1);
    ex("w0 wm", S_WM, 32'h40);

    nxt(); enable_load_activation_data = 1; infifo_is_empty = 1;
    ex("uf as", S_AS, 0);
    ex("uf set", S_UF, 1);
    nxt();
    ex("uf hold", S_UF, 1);
    nxt(); enable_load_activation_data = 1;
    ex("ld as", S_AS, 1);
    ex("ld uf", S_UF, 1);
    nxt(); ld_max_cnt = 1; max_cnt_from_cu = 2;
    ex("clr uf", S_UF, 0);
    ex("clr as", S_AS, 0);
    nxt(); enable_store_activation_data = 1; outfifo_is_full = 1;
    ex("ov ss", S_SS, 0);
    ex("ov set", S_OV, 1);
    nxt(); enable_store_activation_data = 1;
    ex("st ss", S_SS, 1);
    ex("st ov", S_OV, 1);
    nxt(); ld_max_cnt = 1; max_cnt_from_cu = 2;
    enable_load_activation_data = 1; infifo_is_empty = 1;
    ex("setwin uf", S_UF, 1);
    ex("setwin ov", S_OV, 0);

    nxt(); ld_max_cnt = 1; max_cnt_from_cu = 2;
    ld_max_down_cnt = 1; max_down_cnt_from_cu = 3;
    ld_max_cnt_weight = 1; max_cnt_weight_from_cu = 3;
    wm_base_addr = 32'h10;
    ex("mid ld act", S_ACT, 0);
    ex("mid ld out", S_OUT, 3);
    ex("mid ld wm", S_WM, 32'h10);
    nxt(); enable_cnt = 1; enable_down_cnt = 1;
    enable_cnt_weight = 1;
    ex("mid en act", S_ACT, 1);
    ex("mid en out", S_OUT, 2);
    nxt(); enable_cnt_weight = 1;
    enable_store_activation_data = 1; outfifo_is_full = 1;
    ex("mid wm", S_WM, 32'h12);
    ex("mid ov", S_OV, 1);
    nxt(); reset = 1; enable_cnt = 1; enable_down_cnt = 1;
    enable_cnt_weight = 1;
    ex_all_reset("midrst");

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      $display("FAIL pending got=%0d want=0", q.size());
      total += q.size();
      bad   += q.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ls_array_sequencer.md
Name: ls_array_sequencer

Overview:
- Load/store-array sequencer, directly downstream of the DTPU control unit.
- Turns the control unit's counter-load/enable pulses and precision-dependent maxima into:
  - weight-memory row addresses,
  - activation lane selects for unpacking the input FIFO word,
  - output lane selects for packing the output FIFO word.
- Also qualifies FIFO strobes against empty/full and flags protocol errors.
- All outputs are registered and feed the MXU load/store datapath.

Parameters:
- ROWS, 3, MXU rows; number of weight rows loaded per tile.
- COLUMNS, 3, MXU columns.
- DATA_WIDTH_FIFO_IN, 64, input FIFO word width; informational only, the lane count comes from the max inputs.
- ADDRESS_SIZE_WMEMORY, 32, weight-memory address width.
- CW, $clog2(COLUMNS)+1, width of the column up/down counters.
- RW, $clog2(ROWS)+1, width of the weight counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wm_base_addr  in  ADDRESS_SIZE_WMEMORY  weight tile base address, sampled on ld_max_cnt_weight
- enable_cnt  in  1  advance activation up-counter
- ld_max_cnt  in  1  load up-counter maximum, clear counter
- max_cnt_from_cu  in  CW  up-counter maximum
- enable_down_cnt  in  1  advance store down-counter
- ld_max_down_cnt  in  1  load down-counter
- max_down_cnt_from_cu  in  CW  down-counter maximum
- enable_cnt_weight  in  1  advance weight counter
- ld_max_cnt_weight  in  1  load weight maximum, clear counter
- max_cnt_weight_from_cu  in  RW  weight rows per tile
- enable_load_activation_data  in  1  request activation word from input FIFO
- enable_store_activation_data  in  1  request result word into output FIFO
- infifo_is_empty  in  1  input FIFO empty
- outfifo_is_full  in  1  output FIFO full
- wm_address  out  ADDRESS_SIZE_WMEMORY  weight row address (wm_base + weight count)
- act_lane_sel  out  CW  current activation lane (up-count value)
- out_lane_sel  out  CW  current output lane (down-count value)
- act_load_strobe  out  1  qualified input FIFO pop
- store_strobe  out  1  qualified output FIFO push
- cnt_wrap  out  1  one-cycle pulse when the up-counter wraps
- down_wrap  out  1  one-cycle pulse when the down-counter reloads
- weight_done  out  1  level: all weight rows addressed
- underflow_err  out  1  sticky: load requested while FIFO empty
- overflow_err  out  1  sticky: store requested while FIFO full

Behaviour:
- Reset (sync, active-high, dominates every other input):
  - all counters, maxima, wm_base and outputs go to 0;
  - exception: weight_done resets to 1, because the weight maximum is 0.
- Every output is registered. Input at edge N is visible after edge N+1.
- Up-counter:
  - ld_max_cnt: max_u<=max_cnt_from_cu, cnt<=0.
  - Else if enable_cnt: if cnt==max_u, cnt<=0 and pulse cnt_wrap; else cnt<=cnt+1.
  - max_u==0: cnt stays 0 and cnt_wrap pulses on every enabled cycle.
  - Load wins over enable in the same cycle; no wrap pulse on a load.
- Down-counter:
  - ld_max_down_cnt: max_d and dcnt <= max_down_cnt_from_cu.
  - Else if enable_down_cnt: if dcnt==0, dcnt<=max_d and pulse down_wrap; else dcnt<=dcnt-1.
  - Load wins over enable in the same cycle.
- Weight counter:
  - ld_max_cnt_weight: max_w<=max_cnt_weight_from_cu, wcnt<=0, wm_base<=wm_base_addr.
  - Else if enable_cnt_weight && wcnt<max_w: wcnt<=wcnt+1.
  - Saturates at max_w, never wraps.
  - weight_done = (wcnt==max_w).
  - wm_address = wm_base + wcnt, zero-extended, modulo 2^ADDRESS_SIZE_WMEMORY.
- FIFO strobes:
  - act_load_strobe = enable_load_activation_data && !infifo_is_empty.
  - store_strobe = enable_store_activation_data && !outfifo_is_full.
- Error flags:
  - A request blocked by empty sets underflow_err; a request blocked by full sets overflow_err.
  - Both flags are sticky and are cleared only by reset or ld_max_cnt.
  - If ld_max_cnt and a new error occur in the same cycle, the set wins.
- Simultaneous events:
  - All three counters are independent and may load or advance in the same cycle.
  - Strobes are independent of the counters; the sequencer never stalls a counter on a blocked strobe. Stalling is the control unit's job.
- Reset mid-operation: the state is discarded immediately and no pulse is emitted on the reset edge.

Decomposition:
- Shared package, extended into precision_def.vh / csr_definition.vh as a new include: lane-count constants per precision (INT8=8, INT16=4, INT32=2, INT64=1 lanes per 64-bit word).
- Natural sub-module: ls_mod_counter, a parameterised width counter with load/enable and a wrap or saturate mode select.
  - Instantiated three times: up-wrap, down-reload, up-saturate.

Test Plan:
- Reset asserted 3 cycles, then released → all outputs 0, weight_done=1; after ld_max_cnt_weight with max=3, weight_done=0.
- ld_max_cnt with max=2, then 7 cycles of enable_cnt → act_lane_sel 0,1,2,0,1,2,0; cnt_wrap high the cycle after the 3rd and the 6th enables.
- ld_max_down_cnt with max=3, then 5 enables → out_lane_sel 3,2,1,0,3; down_wrap pulses once; ld asserted together with enable → value 3, no pulse.
- wm_base_addr=0x100, ld_max_cnt_weight with max=3, then 5 enables → wm_address 0x100,0x101,0x102,0x103 and holds; weight_done=1 from the 3rd enable on.
- enable_load_activation_data with infifo_is_empty=1 → act_load_strobe=0, underflow_err=1 and stays set; ld_max_cnt → cleared next cycle. Mirror case: store with outfifo_is_full=1 → overflow_err=1.
- Reset pulsed in the middle of counting with cnt=1, dcnt=2, wcnt=2 → next cycle all counters 0, no wrap pulse, errors cleared.
